// File: rtl/ahb_apb_pkg.sv
// Shared encodings, address-map constants and error-FSM state type for the AHB slave interface.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
   localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
   localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
   localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
   localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
   localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } err_state_t;

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder producing the one-hot peripheral select.
module ahb_addr_decode
   import ahb_apb_pkg::*;
(
   input  logic [31:0] HADDR,
   output logic [2:0]  tempselx
);

   always_comb begin
      tempselx = 3'b000;
      if (HADDR >= REGION0_BASE && HADDR <= REGION0_LIMIT)
         tempselx = 3'b001;
      else if (HADDR >= REGION1_BASE && HADDR <= REGION1_LIMIT)
         tempselx = 3'b010;
      else if (HADDR >= REGION2_BASE && HADDR <= REGION2_LIMIT)
         tempselx = 3'b100;
   end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end: decode, address/data pipeline and two-cycle ERROR response.
// Define AHB_SLV_ERR_RESP_EN to build the error-response FSM; otherwise unmapped accesses are dropped.
module ahb_slave_if
   import ahb_apb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HWRITE,
   input  logic        HREADYin,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic        apb_hready,
   output logic        HREADYout,
   output logic [1:0]  HRESP,
   output logic        valid,
   output logic [2:0]  tempselx,
   output logic [31:0] haddr1,
   output logic [31:0] haddr2,
   output logic [31:0] hwdata1,
   output logic [31:0] hwdata2,
   output logic        hwritereg
);

   logic accept;

   ahb_addr_decode u_decode (
      .HADDR    (HADDR),
      .tempselx (tempselx)
   );

   assign accept = HREADYin && HREADYout && is_active(HTRANS);
   assign valid  = accept && (tempselx != 3'b000);

`ifdef AHB_SLV_ERR_RESP_EN
   err_state_t state;
   logic       err_stall;
   logic       unmapped_hit;

   assign unmapped_hit = accept && (tempselx == 3'b000);

   // ERR1 stalls the master, ERR2 completes the ERROR; ERR2 still accepts a new transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_OK;
         HRESP     <= HRESP_OKAY;
         err_stall <= 1'b0;
      end else begin
         case (state)
            ST_OK: begin
               if (unmapped_hit) begin
                  state     <= ST_ERR1;
                  HRESP     <= HRESP_ERROR;
                  err_stall <= 1'b1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HRESP     <= HRESP_ERROR;
               err_stall <= 1'b0;
            end
            ST_ERR2: begin
               if (unmapped_hit) begin
                  state     <= ST_ERR1;
                  HRESP     <= HRESP_ERROR;
                  err_stall <= 1'b1;
               end else begin
                  state     <= ST_OK;
                  HRESP     <= HRESP_OKAY;
                  err_stall <= 1'b0;
               end
            end
            default: begin
               state     <= ST_OK;
               HRESP     <= HRESP_OKAY;
               err_stall <= 1'b0;
            end
         endcase
      end
   end

   assign HREADYout = (state == ST_OK) ? apb_hready : !err_stall;
`else
   assign HRESP     = HRESP_OKAY;
   assign HREADYout = apb_hready;
`endif

   // The pipeline freezes whenever the master is being stalled.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         haddr1    <= '0;
         haddr2    <= '0;
         hwdata1   <= '0;
         hwdata2   <= '0;
         hwritereg <= 1'b0;
      end else if (HREADYout) begin
         haddr1    <= HADDR;
         haddr2    <= haddr1;
         hwdata1   <= HWDATA;
         hwdata2   <= hwdata1;
         hwritereg <= HWRITE;
      end
   end

endmodule
